// File: rtl/wash_ctrl_param.sv
// Washing-machine sequencer: OFF/IDLE/FILL/WASH/RDRAIN/RINSE/DRAIN/SPIN/DONE/FAULT with pause and fill timeout.
// Button actions land 1 cycle after the registered edge; no backpressure, pause freezes timers and drives.
module wash_ctrl_param #(
    parameter int TICK_DIV = 4,
    parameter int TW       = 6,
    parameter int PW       = 5,
    parameter int WASH_T   = 6,
    parameter int RINSE_T  = 4,
    parameter int DRAIN_T  = 2,
    parameter int SPIN_T   = 3,
    parameter int RINSES   = 2,
    parameter int FILL_TO  = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          power,
    input  logic          mod,
    input  logic          ss,
    input  logic          water,
    output logic [1:0]    mode_o,
    output logic [TW-1:0] tt,
    output logic [PW-1:0] tm,
    output logic          li,
    output logic          lo,
    output logic          lw,
    output logic          lr,
    output logic          lsp,
    output logic          p,
    output logic          s,
    output logic          ld,
    output logic          fault
);

    localparam int DW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FW   = $clog2(FILL_TO + 1);
    localparam int RW   = $clog2(RINSES + 1);
    localparam int LOOP = RINSES * (RINSE_T + DRAIN_T);
    localparam int TOT0 = WASH_T + DRAIN_T + LOOP + SPIN_T;
    localparam int TOT1 = WASH_T + DRAIN_T + SPIN_T;
    localparam int TOT2 = LOOP + SPIN_T;
    localparam int TOT3 = SPIN_T;

    typedef enum logic [3:0] {
        ST_OFF, ST_IDLE, ST_FILL, ST_WASH, ST_RDRAIN,
        ST_RINSE, ST_DRAIN, ST_SPIN, ST_DONE, ST_FAULT
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_mode, w_mode_nxt;
    logic [TW-1:0]   r_tt, w_tt_nxt;
    logic [PW-1:0]   r_tm, w_tm_nxt;
    logic [DW-1:0]   r_div, w_div_nxt;
    logic [FW-1:0]   r_fill, w_fill_nxt;
    logic [RW-1:0]   r_rinse, w_rinse_nxt;
    logic            r_paused, w_paused_nxt;
    logic            r_wdone, w_wdone_nxt;
    logic            r_pw_d, r_md_d, r_ss_d;
    logic            r_pw_e, r_md_e, r_ss_e;
    logic            w_run, w_tick, w_act;

    function automatic logic [PW-1:0] phase_len(input state_t st);
        case (st)
            ST_WASH:            phase_len = PW'(WASH_T);
            ST_RINSE:           phase_len = PW'(RINSE_T);
            ST_RDRAIN, ST_DRAIN: phase_len = PW'(DRAIN_T);
            ST_SPIN:            phase_len = PW'(SPIN_T);
            default:            phase_len = '0;
        endcase
    endfunction

    function automatic logic is_run(input state_t st);
        is_run = (st >= ST_FILL) && (st <= ST_SPIN);
    endfunction

    assign w_run  = is_run(r_state);
    assign w_act  = w_run && !r_paused;
    assign w_tick = w_act && (r_div == DW'(TICK_DIV - 1));

    // Edge pulses are registered, so every button action lands one cycle after its edge is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pw_d <= 1'b0; r_md_d <= 1'b0; r_ss_d <= 1'b0;
            r_pw_e <= 1'b0; r_md_e <= 1'b0; r_ss_e <= 1'b0;
        end else begin
            r_pw_d <= power; r_md_d <= mod; r_ss_d <= ss;
            r_pw_e <= power & ~r_pw_d;
            r_md_e <= mod & ~r_md_d;
            r_ss_e <= ss & ~r_ss_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_OFF;
            r_mode   <= 2'd0;
            r_tt     <= '0;
            r_tm     <= '0;
            r_div    <= '0;
            r_fill   <= '0;
            r_rinse  <= '0;
            r_paused <= 1'b0;
            r_wdone  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mode   <= w_mode_nxt;
            r_tt     <= w_tt_nxt;
            r_tm     <= w_tm_nxt;
            r_div    <= w_div_nxt;
            r_fill   <= w_fill_nxt;
            r_rinse  <= w_rinse_nxt;
            r_paused <= w_paused_nxt;
            r_wdone  <= w_wdone_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_mode_nxt   = r_mode;
        w_tt_nxt     = r_tt;
        w_tm_nxt     = r_tm;
        w_div_nxt    = r_div;
        w_fill_nxt   = r_fill;
        w_rinse_nxt  = r_rinse;
        w_paused_nxt = r_paused;
        w_wdone_nxt  = r_wdone;

        if (w_act) begin
            w_div_nxt = w_tick ? '0 : r_div + DW'(1);
            if (w_tick) begin
                if (r_state == ST_FILL) begin
                    w_fill_nxt = r_fill + FW'(1);
                end else begin
                    if (r_tm != '0) w_tm_nxt = r_tm - PW'(1);
                    if (r_tt != '0) w_tt_nxt = r_tt - TW'(1);
                end
            end
        end

        if (r_pw_e) begin
            if (r_state == ST_OFF) begin
                w_state_nxt = ST_IDLE;
            end else begin
                w_state_nxt = ST_OFF;
                w_tt_nxt    = '0;
            end
        end else begin
            if (w_run && r_ss_e) w_paused_nxt = !r_paused;
            case (r_state)
                ST_IDLE: begin
                    if (r_ss_e) begin
                        w_rinse_nxt = '0;
                        w_wdone_nxt = 1'b0;
                        case (r_mode)
                            2'd0:    w_tt_nxt = TW'(TOT0);
                            2'd1:    w_tt_nxt = TW'(TOT1);
                            2'd2:    w_tt_nxt = TW'(TOT2);
                            default: w_tt_nxt = TW'(TOT3);
                        endcase
                        w_state_nxt = (r_mode == 2'd3) ? ST_SPIN : ST_FILL;
                    end else if (r_md_e) begin
                        w_mode_nxt = r_mode + 2'd1;
                    end
                end
                ST_FILL: begin
                    if (!r_paused) begin
                        if (water)
                            w_state_nxt = (r_mode <= 2'd1 && !r_wdone) ? ST_WASH : ST_RINSE;
                        else if (w_tick && r_fill == FW'(FILL_TO - 1))
                            w_state_nxt = ST_FAULT;
                    end
                end
                ST_WASH: if (w_tick && r_tm == PW'(1)) begin
                    w_wdone_nxt = 1'b1;
                    w_state_nxt = ST_RDRAIN;
                end
                ST_RDRAIN: if (w_tick && r_tm == PW'(1))
                    w_state_nxt = (r_mode == 2'd1) ? ST_SPIN : ST_FILL;
                ST_RINSE: if (w_tick && r_tm == PW'(1))
                    w_state_nxt = ST_DRAIN;
                ST_DRAIN: if (w_tick && r_tm == PW'(1)) begin
                    w_rinse_nxt = r_rinse + RW'(1);
                    w_state_nxt = (int'(r_rinse) + 1 >= RINSES) ? ST_SPIN : ST_FILL;
                end
                ST_SPIN: if (w_tick && r_tm == PW'(1))
                    w_state_nxt = ST_DONE;
                ST_DONE: if (r_ss_e || r_md_e)
                    w_state_nxt = ST_IDLE;
                default: ;
            endcase
        end

        // Every state entry restarts the tick phase and loads the new phase length.
        if (w_state_nxt != r_state) begin
            w_div_nxt  = '0;
            w_fill_nxt = '0;
            w_tm_nxt   = phase_len(w_state_nxt);
            if (!is_run(w_state_nxt)) w_paused_nxt = 1'b0;
            if (w_state_nxt == ST_DONE) w_tt_nxt = '0;
        end
    end

    assign mode_o = r_mode;
    assign tt     = r_tt;
    assign tm     = r_tm;
    assign li     = (r_state == ST_FILL) && !r_paused;
    assign lw     = (r_state == ST_WASH) && !r_paused;
    assign lr     = (r_state == ST_RINSE) && !r_paused;
    assign lsp    = (r_state == ST_SPIN) && !r_paused;
    assign lo     = (r_state == ST_RDRAIN || r_state == ST_DRAIN || r_state == ST_SPIN) && !r_paused;
    assign p      = (r_state != ST_OFF);
    assign s      = w_act;
    assign ld     = (r_state == ST_DONE);
    assign fault  = (r_state == ST_FAULT);

endmodule

// File: tb/tb_wash_ctrl_param.sv
// Directed bench for wash_ctrl_param: full, quick, rinse and spin-only runs, pause, fill fault, priority, reset.
// Inputs are driven 1ns after posedge and outputs sampled at the same point.
module tb_wash_ctrl_param;

    logic       clk, rst, power, mod, ss, water;
    logic [1:0] mode_o;
    logic [5:0] tt;
    logic [4:0] tm;
    logic       li, lo, lw, lr, lsp, p, s, ld, fault;
    logic [8:0] w_out;

    int n_checks = 0;
    int n_errors = 0;

    wash_ctrl_param dut (
        .clk(clk), .rst(rst), .power(power), .mod(mod), .ss(ss), .water(water),
        .mode_o(mode_o), .tt(tt), .tm(tm),
        .li(li), .lo(lo), .lw(lw), .lr(lr), .lsp(lsp),
        .p(p), .s(s), .ld(ld), .fault(fault)
    );

    assign w_out = {li, lo, lw, lr, lsp, p, s, ld, fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle pulse on {power, mod, ss}; returns once the action has taken effect.
    task automatic press(input logic [2:0] m);
        {power, mod, ss} = m;
        cyc(1);
        {power, mod, ss} = 3'b000;
        cyc(1);
    endtask

    int cnt_li, cnt_lo, cnt_lw, cnt_lr, cnt_lsp, tt_spin, guard;

    task automatic run_to_done();
        guard = 0;
        tt_spin = -1;
        while (ld !== 1'b1 && guard < 400) begin
            cyc(1);
            guard++;
            cnt_li  += int'(li);
            cnt_lo  += int'(lo);
            cnt_lw  += int'(lw);
            cnt_lr  += int'(lr);
            cnt_lsp += int'(lsp);
            if (lsp && tt_spin < 0) tt_spin = int'(tt);
        end
    endtask

    initial begin
        rst = 1'b1; power = 1'b0; mod = 1'b0; ss = 1'b0; water = 1'b0;
        cyc(3);
        check("rst_out", w_out, 0);
        check("rst_mode", mode_o, 0);
        check("rst_tt", tt, 0);
        check("rst_tm", tm, 0);
        rst = 1'b0;

        // Full programme (mode 0)
        press(3'b100);
        check("on_p", w_out, 9'h008);
        press(3'b001);
        check("m0_fill_li", li, 1);
        check("m0_fill_tt", tt, 23);
        check("m0_fill_tm", tm, 0);
        water = 1'b1;
        cyc(1);
        check("m0_wash_lw", lw, 1);
        check("m0_wash_li", li, 0);
        check("m0_wash_tm", tm, 6);
        check("m0_wash_tt", tt, 23);
        cnt_li = 0; cnt_lo = 0; cnt_lw = 1; cnt_lr = 0; cnt_lsp = 0;
        run_to_done();
        check("m0_done_ld", ld, 1);
        check("m0_done_tt", tt, 0);
        check("m0_done_tm", tm, 0);
        check("m0_done_s", s, 0);
        check("m0_cnt_lw", cnt_lw, 24);
        check("m0_cnt_lr", cnt_lr, 32);
        check("m0_cnt_lo", cnt_lo, 36);
        check("m0_cnt_lsp", cnt_lsp, 12);
        check("m0_cnt_li", cnt_li, 2);
        check("m0_tt_spin", tt_spin, 3);

        // Quick programme (mode 1) after 5 mode presses
        press(3'b001);
        check("done_to_idle_ld", ld, 0);
        repeat (5) press(3'b010);
        check("mode_wrap", mode_o, 1);
        press(3'b001);
        check("m1_fill_li", li, 1);
        check("m1_fill_tt", tt, 11);
        cnt_li = 0; cnt_lo = 0; cnt_lw = 0; cnt_lr = 0; cnt_lsp = 0;
        run_to_done();
        check("m1_done_ld", ld, 1);
        check("m1_cnt_lr", cnt_lr, 0);
        check("m1_cnt_lw", cnt_lw, 24);
        check("m1_tt_spin", tt_spin, 3);
        press(3'b010);
        check("done_mod_idle", ld, 0);
        check("done_mod_keep", mode_o, 1);
        repeat (3) press(3'b010);
        check("mode_back0", mode_o, 0);

        // Pause and resume in WASH
        press(3'b001);
        guard = 0;
        while (!(lw === 1'b1 && tm === 5'd3) && guard < 100) begin
            cyc(1);
            guard++;
        end
        check("pz_tm3", tm, 3);
        check("pz_tt20", tt, 20);
        press(3'b001);
        check("pz_lw", lw, 0);
        check("pz_s", s, 0);
        cyc(40);
        check("pz_hold_tm", tm, 3);
        check("pz_hold_tt", tt, 20);
        check("pz_hold_p", p, 1);
        press(3'b001);
        check("rs_lw", lw, 1);
        check("rs_s", s, 1);
        check("rs_tm", tm, 3);
        guard = 0;
        while (tm === 5'd3 && guard < 8) begin
            cyc(1);
            guard++;
        end
        check("rs_tm2", tm, 2);
        check("rs_tt19", tt, 19);
        press(3'b100);
        check("off_out", w_out, 0);
        check("off_mode", mode_o, 0);

        // Fill timeout
        press(3'b100);
        water = 1'b0;
        press(3'b001);
        cyc(79);
        check("ft_before", fault, 0);
        check("ft_before_li", li, 1);
        cyc(1);
        check("ft_fault", fault, 1);
        check("ft_li", li, 0);
        check("ft_s", s, 0);
        press(3'b100);
        check("ft_off_fault", fault, 0);
        check("ft_off_p", p, 0);

        // Spin only (mode 3)
        press(3'b100);
        repeat (3) press(3'b010);
        check("m3_mode", mode_o, 3);
        water = 1'b1;
        press(3'b001);
        check("m3_lsp", lsp, 1);
        check("m3_lo", lo, 1);
        check("m3_tt", tt, 3);
        check("m3_tm", tm, 3);
        cyc(11);
        check("m3_tt1", tt, 1);
        check("m3_ld0", ld, 0);
        cyc(1);
        check("m3_ld1", ld, 1);
        check("m3_tt0", tt, 0);

        // Simultaneous edges in SPIN: power wins
        press(3'b001);
        press(3'b001);
        check("sim_spin", lsp, 1);
        cyc(2);
        press(3'b111);
        check("sim_out", w_out, 0);
        check("sim_mode", mode_o, 3);

        // Rinse-only programme (mode 2) and reset during RINSE
        press(3'b100);
        repeat (3) press(3'b010);
        check("m2_mode", mode_o, 2);
        press(3'b001);
        check("m2_fill_tt", tt, 15);
        check("m2_fill_li", li, 1);
        cyc(1);
        check("m2_rinse_lr", lr, 1);
        check("m2_rinse_tm", tm, 4);
        rst = 1'b1;
        cyc(1);
        check("mid_rst_out", w_out, 0);
        check("mid_rst_mode", mode_o, 0);
        check("mid_rst_tt", tt, 0);
        check("mid_rst_tm", tm, 0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
